ising_lattice_sweeper: RTL and testbench

- Owns an N x N Ising spin lattice and sequences checkerboard Monte Carlo sweeps.
- Sits directly upstream of the Spin update stage. Each cycle it drives one site's spin, its four periodic neighbours, enable and rand32 into Spin.
- Writes the returned final_spin_val back into the lattice.
- Also contains the xorshift32 generator that supplies rand32.

---
 rtl/ising_lattice_sweeper.sv | 190 +++++++++++++++++++
 tb/tb_ising_lattice_sweeper.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ising_lattice_sweeper.sv
`default_nettype none
// ============================================================================
// ising_lattice_sweeper : N x N Ising lattice, checkerboard sweep sequencer and
// xorshift32 RNG. Define ISING_MAGNETIZATION_EN to add the running mag output.
// Revision: 1.0
// ============================================================================
module ising_lattice_sweeper #(
  parameter int N        = 8,
  parameter int SWEEPS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     randomize,
  input  logic [SWEEPS_W-1:0]      num_sweeps,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic [SWEEPS_W-1:0]      sweep_count,
  output logic                     spin_val,
  output logic                     left,
  output logic                     right,
  output logic                     top,
  output logic                     bottom,
  output logic                     enable,
  output logic [31:0]              rand32,
  input  logic                     final_spin_val,
  input  logic [2*$clog2(N)-1:0]   rd_addr,
  output logic                     rd_spin
`ifdef ISING_MAGNETIZATION_EN
  ,
  output logic signed [2*$clog2(N)+1:0] mag
`endif
);

  localparam int          LG        = $clog2(N);
  localparam int          AW        = 2 * LG;
  localparam int          NN        = N * N;
  localparam int          HALF      = NN / 2;
  localparam logic [31:0] RNG_RESET = 32'h2545F491;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RED   = 3'd2;
  localparam logic [2:0] S_BLACK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [31:0]         rng_q, rng_d;
  logic [SWEEPS_W-1:0] num_q, num_d;
  logic [SWEEPS_W-1:0] sweep_q, sweep_d;
  logic [NN-1:0]       lat_q, lat_d;

  logic          w_phase, w_active, w_last_init, w_last_phase, w_more;
  logic [LG-1:0] w_y, w_x, w_xl, w_xr, w_yt, w_yb;
  logic [AW-1:0] w_widx;
  logic          w_wbit;
  logic [31:0]   w_x1, w_x2, w_rng_next;

  assign w_x1       = rng_q ^ (rng_q << 13);
  assign w_x2       = w_x1 ^ (w_x1 >> 17);
  assign w_rng_next = w_x2 ^ (w_x2 << 5);

  assign w_phase      = (state_q == S_RED) || (state_q == S_BLACK);
  assign w_active     = w_phase || (state_q == S_INIT);
  assign w_last_init  = (cnt_q == AW'(NN - 1));
  assign w_last_phase = (cnt_q == AW'(HALF - 1));
  assign w_more       = ((sweep_q + SWEEPS_W'(1)) < num_q);

  // Row is k / (N/2); column parity alternates per row and flips for BLACK.
  assign w_y  = cnt_q[AW-2:LG-1];
  assign w_x  = {cnt_q[LG-2:0], w_y[0] ^ (state_q == S_BLACK)};
  assign w_xl = w_x - LG'(1);
  assign w_xr = w_x + LG'(1);
  assign w_yt = w_y - LG'(1);
  assign w_yb = w_y + LG'(1);

  assign w_widx = (state_q == S_INIT) ? cnt_q : {w_y, w_x};
  assign w_wbit = (state_q == S_INIT) ? rng_q[0] : final_spin_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (randomize)               state_d = S_INIT;
          else if (num_sweeps == '0)   state_d = S_DONE;
          else                         state_d = S_RED;
        end
      end
      S_INIT:  if (w_last_init)  state_d = (num_q == '0) ? S_DONE : S_RED;
      S_RED:   if (w_last_phase) state_d = S_BLACK;
      S_BLACK: if (w_last_phase) state_d = w_more ? S_RED : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    enable   = w_phase;
    spin_val = 1'b0;
    left     = 1'b0;
    right    = 1'b0;
    top      = 1'b0;
    bottom   = 1'b0;
    if (w_phase) begin
      spin_val = lat_q[{w_y, w_x}];
      left     = lat_q[{w_y, w_xl}];
      right    = lat_q[{w_y, w_xr}];
      top      = lat_q[{w_yt, w_x}];
      bottom   = lat_q[{w_yb, w_x}];
    end
  end

  always_comb begin
    cnt_d   = (w_active && (state_d == state_q)) ? cnt_q + AW'(1) : '0;
    rng_d   = rng_q;
    num_d   = num_q;
    sweep_d = sweep_q;
    lat_d   = lat_q;
    if (state_q == S_IDLE) begin
      // Seed load wins the RNG even when start is accepted in the same cycle.
      if (seed_load) rng_d = (seed == 32'h0) ? 32'h1 : seed;
      if (start) begin
        num_d   = num_sweeps;
        sweep_d = '0;
      end
    end else if (w_active) begin
      rng_d = w_rng_next;
    end
    if ((state_q == S_BLACK) && w_last_phase) sweep_d = sweep_q + SWEEPS_W'(1);
    if (w_active) lat_d[w_widx] = w_wbit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rng_q   <= RNG_RESET;
      num_q   <= '0;
      sweep_q <= '0;
      lat_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      rng_q   <= rng_d;
      num_q   <= num_d;
      sweep_q <= sweep_d;
      lat_q   <= lat_d;
    end
  end

  assign rand32      = rng_q;
  assign sweep_count = sweep_q;
  assign rd_spin     = lat_q[rd_addr];

`ifdef ISING_MAGNETIZATION_EN
  localparam int MW = AW + 2;
  logic signed [MW-1:0] mag_q, mag_d;

  always_comb begin
    mag_d = mag_q;
    if (w_active && (lat_q[w_widx] != w_wbit)) begin
      mag_d = w_wbit ? (mag_q + MW'(2)) : (mag_q - MW'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= MW'(NN);
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ising_lattice_sweeper.sv
`default_nettype none
// tb_ising_lattice_sweeper : directed bench for ising_lattice_sweeper at N=4,
// with an inverting Spin stub and a bench-side lattice/RNG model.
`timescale 1ns/1ps
module tb_ising_lattice_sweeper;

  localparam int N  = 4;
  localparam int NN = 16;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          randomize = 1'b0;
  logic [SW-1:0] num_sweeps = '0;
  logic          seed_load = 1'b0;
  logic [31:0]   seed = '0;
  logic          busy, done, enable;
  logic          spin_val, left, right, top, bottom;
  logic [SW-1:0] sweep_count;
  logic [31:0]   rand32;
  logic          final_spin_val;
  logic [3:0]    rd_addr = '0;
  logic          rd_spin;
`ifdef ISING_MAGNETIZATION_EN
  logic signed [5:0] mag;
`endif

  int          checks = 0;
  int          failures = 0;
  logic        mdl [NN];
  logic [31:0] rng_m;

  assign final_spin_val = ~spin_val;

  always #5 clk = ~clk;

  ising_lattice_sweeper #(.N(N), .SWEEPS_W(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .randomize      (randomize),
    .num_sweeps     (num_sweeps),
    .seed_load      (seed_load),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .sweep_count    (sweep_count),
    .spin_val       (spin_val),
    .left           (left),
    .right          (right),
    .top            (top),
    .bottom         (bottom),
    .enable         (enable),
    .rand32         (rand32),
    .final_spin_val (final_spin_val),
    .rd_addr        (rd_addr),
    .rd_spin        (rd_spin)
`ifdef ISING_MAGNETIZATION_EN
    ,
    .mag            (mag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic check_lattice(input string tag);
    for (int i = 0; i < NN; i++) begin
      rd_addr = 4'(i);
      #1;
      check(tag, 32'(rd_spin), 32'(mdl[i]));
    end
  endtask

  task automatic check_mag();
`ifdef ISING_MAGNETIZATION_EN
    int ones;
    ones = 0;
    for (int i = 0; i < NN; i++) if (mdl[i]) ones++;
    check("mag", 32'(mag), 32'(2 * ones - NN));
`endif
  endtask

  task automatic reset_model();
    for (int i = 0; i < NN; i++) mdl[i] = 1'b1;
    rng_m = 32'h2545F491;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_en"}, 32'(enable), 32'd0);
    check({tag, "_nbr"}, 32'({spin_val, left, right, top, bottom}), 32'd0);
  endtask

  // One run: cycle c is the interval ending at the c-th edge after start is sampled.
  task automatic do_run(input int nsw, input bit rnd, input bit sl, input logic [31:0] sd,
                        input int rst_at, input int poke_at);
    int         base, done_c, pend, j, k, p, x, y, s;
    bit         en, poked;
    logic [4:0] e5;
    base   = rnd ? NN + 1 : 1;
    done_c = base + NN * nsw;
    pend   = -1;
    poked  = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    randomize  = rnd;
    num_sweeps = SW'(nsw);
    seed_load  = sl;
    seed       = sd;
    @(posedge clk);
    if (sl) rng_m = (sd == 32'h0) ? 32'h1 : sd;
    #1;
    start      = 1'b0;
    seed_load  = 1'b0;
    num_sweeps = SW'(nsw + 3);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      if (poked) begin
        start = 1'b0;
        poked = 1'b0;
      end
      if (pend >= 0) begin
        check("wr", 32'(rd_spin), 32'(mdl[pend]));
        pend = -1;
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst");
        check("rst_rng", rand32, 32'h2545F491);
        check("rst_sweep_count", 32'(sweep_count), 32'd0);
        reset_model();
        check_lattice("rst_lattice");
        check_mag();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("done", 32'(done), 32'(c == done_c));
      check("busy", 32'(busy), 32'(c <= done_c));
      en = (c >= base) && (c < done_c);
      check("en", 32'(enable), 32'(en));
      if (rnd && c <= NN) begin
        if (sl && sd == 32'h0 && c == 1) check("rng_first", rand32, 32'h00000001);
        if (sl && sd == 32'h0 && c == 2) check("rng_second", rand32, 32'h00042021);
        check("rng_init", rand32, rng_m);
        mdl[c-1] = rng_m[0];
        rng_m = xs(rng_m);
      end
      if (en) begin
        j = c - base;
        k = j % (NN / 2);
        p = (j / (NN / 2)) % 2;
        y = k / (N / 2);
        x = 2 * (k % (N / 2)) + ((y + p) % 2);
        s = y * N + x;
        e5 = {mdl[s], mdl[y*N + (x+N-1)%N], mdl[y*N + (x+1)%N],
              mdl[((y+N-1)%N)*N + x], mdl[((y+1)%N)*N + x]};
        check("nbr", 32'({spin_val, left, right, top, bottom}), 32'(e5));
        check("rng_sweep", rand32, rng_m);
        rng_m  = xs(rng_m);
        mdl[s] = ~mdl[s];
        rd_addr = 4'(s);
        pend = s;
      end
      if (c == poke_at) begin
        start      = 1'b1;
        num_sweeps = SW'(nsw + 5);
        poked      = 1'b1;
      end
    end
    check("sweep_count", 32'(sweep_count), 32'(nsw));
    check_idle_outputs("post");
    check_lattice("lattice");
    check_mag();
  endtask

  initial begin
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rng", rand32, 32'h2545F491);
    check("reset_sweep_count", 32'(sweep_count), 32'd0);
    check_lattice("reset_lattice");
    check_mag();
    @(negedge clk);
    rst_n = 1'b1;

    do_run(1, 1'b0, 1'b0, 32'h0, 0, 0);
    do_run(0, 1'b0, 1'b0, 32'h0, 0, 0);
    do_run(0, 1'b1, 1'b1, 32'h0, 0, 0);
    do_run(2, 1'b0, 1'b0, 32'h0, 0, 5);
    do_run(3, 1'b0, 1'b0, 32'h0, 28, 0);
    do_run(1, 1'b0, 1'b0, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
